had_axi_mem_slave: RTL and testbench

- AXI4 responder (slave) that terminates one `if_axi_in`/`if_axi_out`-style master port: INCR bursts, full-width beats, no IDs, BRESP/RRESP implied OKAY.
- Backed by an on-chip line memory with byte-strobe writes.
- Serves as the far end of the hardcloud AXI master ports in loopback builds and block-level benches.
- Write and read channels run as independent state machines.

---
 rtl/had_axi_mem_slave.sv | 165 ++++++++++++++++
 tb/tb_had_axi_mem_slave.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/had_axi_mem_slave.sv
// had_axi_mem_slave: AXI4 INCR-burst responder backed by a byte-strobed line memory.
// Write and read channels are independent FSMs, each holding one outstanding burst.
module had_axi_mem_slave #(
    parameter int C_ADDR_WIDTH     = 64,
    parameter int C_DATA_WIDTH     = 512,
    parameter int C_MEM_DEPTH_LOG2 = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      stall,
    input  logic                      s_awvalid,
    output logic                      s_awready,
    input  logic [C_ADDR_WIDTH-1:0]   s_awaddr,
    input  logic [7:0]                s_awlen,
    input  logic                      s_wvalid,
    output logic                      s_wready,
    input  logic [C_DATA_WIDTH-1:0]   s_wdata,
    input  logic [C_DATA_WIDTH/8-1:0] s_wstrb,
    input  logic                      s_wlast,
    output logic                      s_bvalid,
    input  logic                      s_bready,
    input  logic                      s_arvalid,
    output logic                      s_arready,
    input  logic [C_ADDR_WIDTH-1:0]   s_araddr,
    input  logic [7:0]                s_arlen,
    output logic                      s_rvalid,
    input  logic                      s_rready,
    output logic [C_DATA_WIDTH-1:0]   s_rdata,
    output logic                      s_rlast,
    output logic                      err_wlast,
    output logic [31:0]               wr_bursts,
    output logic [31:0]               rd_bursts
);
    localparam int OFF = $clog2(C_DATA_WIDTH / 8);
    localparam int IW  = C_MEM_DEPTH_LOG2;
    localparam int SW  = C_DATA_WIDTH / 8;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} rstate_t;

    logic [C_DATA_WIDTH-1:0] mem [2**IW];

    wstate_t           ws_q, ws_d;
    logic [IW-1:0]     widx_q, widx_d;
    logic [7:0]        wlen_q, wlen_d, wcnt_q, wcnt_d;
    logic              err_q, err_d;
    logic [31:0]       wrb_q, wrb_d;

    rstate_t           rs_q, rs_d;
    logic [IW-1:0]     ridx_q, ridx_d;
    logic [7:0]        rlen_q, rlen_d, rcnt_q, rcnt_d;
    logic [31:0]       rdb_q, rdb_d;
    logic [C_DATA_WIDTH-1:0] rdata_q;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs, w_end;
    logic unused_addr;

    // Only the line-index field of each address matters
    assign unused_addr = ^{s_awaddr, s_araddr};

    assign s_awready = (ws_q == W_IDLE) && !stall;
    assign s_wready  = (ws_q == W_DATA) && !stall;
    assign s_bvalid  = (ws_q == W_RESP);
    assign s_arready = (rs_q == R_IDLE) && !stall;
    assign s_rvalid  = (rs_q == R_DATA);
    assign s_rlast   = (rs_q == R_DATA) && (rcnt_q == rlen_q);
    assign s_rdata   = rdata_q;
    assign err_wlast = err_q;
    assign wr_bursts = wrb_q;
    assign rd_bursts = rdb_q;

    assign aw_hs = s_awvalid && s_awready;
    assign w_hs  = s_wvalid && s_wready;
    assign b_hs  = s_bvalid && s_bready;
    assign ar_hs = s_arvalid && s_arready;
    assign r_hs  = s_rvalid && s_rready;
    assign w_end = (wcnt_q == wlen_q);

    always_comb begin
        ws_d   = ws_q;
        widx_d = widx_q;
        wlen_d = wlen_q;
        wcnt_d = wcnt_q;
        err_d  = err_q;
        wrb_d  = wrb_q;
        if (aw_hs) begin
            widx_d = s_awaddr[OFF +: IW];
            wlen_d = s_awlen;
            wcnt_d = '0;
            ws_d   = W_DATA;
        end
        // Burst length comes from awlen; wlast is only checked, never obeyed
        if (w_hs) begin
            widx_d = widx_q + 1'b1;
            wcnt_d = wcnt_q + 8'd1;
            err_d  = err_q | (s_wlast != w_end);
            ws_d   = w_end ? W_RESP : W_DATA;
        end
        if (b_hs) begin
            wrb_d = wrb_q + 32'd1;
            ws_d  = W_IDLE;
        end
    end

    always_comb begin
        rs_d   = rs_q;
        ridx_d = ridx_q;
        rlen_d = rlen_q;
        rcnt_d = rcnt_q;
        rdb_d  = rdb_q;
        if (ar_hs) begin
            ridx_d = s_araddr[OFF +: IW];
            rlen_d = s_arlen;
            rcnt_d = '0;
            rs_d   = R_FETCH;
        end
        if (rs_q == R_FETCH)
            rs_d = R_DATA;
        if (r_hs) begin
            rdb_d  = s_rlast ? rdb_q + 32'd1 : rdb_q;
            ridx_d = s_rlast ? ridx_q : ridx_q + 1'b1;
            rcnt_d = s_rlast ? rcnt_q : rcnt_q + 8'd1;
            rs_d   = s_rlast ? R_IDLE : R_FETCH;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ws_q    <= W_IDLE;
            widx_q  <= '0;
            wlen_q  <= '0;
            wcnt_q  <= '0;
            err_q   <= 1'b0;
            wrb_q   <= '0;
            rs_q    <= R_IDLE;
            ridx_q  <= '0;
            rlen_q  <= '0;
            rcnt_q  <= '0;
            rdb_q   <= '0;
            rdata_q <= '0;
        end else begin
            ws_q    <= ws_d;
            widx_q  <= widx_d;
            wlen_q  <= wlen_d;
            wcnt_q  <= wcnt_d;
            err_q   <= err_d;
            wrb_q   <= wrb_d;
            rs_q    <= rs_d;
            ridx_q  <= ridx_d;
            rlen_q  <= rlen_d;
            rcnt_q  <= rcnt_d;
            rdb_q   <= rdb_d;
            if (rs_q == R_FETCH)
                rdata_q <= mem[ridx_q];
        end
    end

    // Non-blocking write beside the registered read gives read-first collisions
    always_ff @(posedge clk) begin
        if (w_hs && !rst)
            for (int b = 0; b < SW; b++)
                if (s_wstrb[b])
                    mem[widx_q][b*8 +: 8] <= s_wdata[b*8 +: 8];
    end
endmodule

// File: tb/tb_had_axi_mem_slave.sv
// tb_had_axi_mem_slave: scenario tasks against a line-array model of the memory.
module tb_had_axi_mem_slave;
    logic         clk = 0;
    logic         rst = 1;
    logic         stall = 0;
    logic         s_awvalid = 0, s_awready;
    logic [63:0]  s_awaddr = '0;
    logic [7:0]   s_awlen = '0;
    logic         s_wvalid = 0, s_wready;
    logic [511:0] s_wdata = '0;
    logic [63:0]  s_wstrb = '0;
    logic         s_wlast = 0;
    logic         s_bvalid, s_bready = 0;
    logic         s_arvalid = 0, s_arready;
    logic [63:0]  s_araddr = '0;
    logic [7:0]   s_arlen = '0;
    logic         s_rvalid, s_rready = 0;
    logic [511:0] s_rdata;
    logic         s_rlast;
    logic         err_wlast;
    logic [31:0]  wr_bursts, rd_bursts;

    had_axi_mem_slave dut (
        .clk(clk), .rst(rst), .stall(stall),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awlen(s_awlen),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
        .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arlen(s_arlen),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rlast(s_rlast),
        .err_wlast(err_wlast), .wr_bursts(wr_bursts), .rd_bursts(rd_bursts)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    logic [511:0] mdl [1024];
    logic [511:0] wd [256];
    logic [63:0]  ws [256];
    logic [511:0] rd [256];
    logic         rl [256];
    bit           pat [4] = '{1, 0, 0, 1};
    int           exp_wr = 0, exp_rd = 0;
    bit           to_flag, early_b, unstable;
    int           stall_leak, b_delay, first_rv;
    logic         b_after;

    function automatic int lidx(input logic [63:0] a);
        return int'((a >> 6) % 1024);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [63:0] addr, input int len, input int bad, input int stall_k);
        int n;
        to_flag = 0; stall_leak = 0; early_b = 0;
        s_awvalid = 1; s_awaddr = addr; s_awlen = len[7:0];
        #1;
        n = 0;
        while (!s_awready && n < 50) begin tick(); n++; end
        if (n >= 50) to_flag = 1;
        tick();
        s_awvalid = 0;
        for (int k = 0; k <= len; k++) begin
            s_wvalid = 1; s_wstrb = ws[k];
            s_wlast = (bad >= 0) ? (k == bad) : (k == len);
            if (k == stall_k) begin
                stall = 1; s_wdata = ~wd[k];
                for (int c = 0; c < 5; c++) begin
                    #1;
                    if (s_wready) stall_leak++;
                    tick();
                end
                stall = 0;
            end
            s_wdata = wd[k];
            #1;
            n = 0;
            while (!s_wready && n < 50) begin tick(); n++; end
            if (n >= 50) to_flag = 1;
            if (s_bvalid) early_b = 1;
            for (int b = 0; b < 64; b++)
                if (ws[k][b]) mdl[(lidx(addr) + k) % 1024][b*8 +: 8] = wd[k][b*8 +: 8];
            tick();
        end
        s_wvalid = 0; s_wlast = 0; s_bready = 1;
        #1;
        b_delay = 0;
        while (!s_bvalid && b_delay < 50) begin tick(); b_delay++; end
        if (b_delay >= 50) to_flag = 1;
        tick();
        b_after = s_bvalid;
        s_bready = 0;
        exp_wr++;
    endtask

    task automatic do_read(input logic [63:0] addr, input int len, input bit use_pat);
        int n, cyc, beat;
        bit held;
        logic [511:0] pd;
        logic pl;
        to_flag = 0; first_rv = -1; unstable = 0; held = 0; pd = '0; pl = 0;
        s_arvalid = 1; s_araddr = addr; s_arlen = len[7:0];
        #1;
        n = 0;
        while (!s_arready && n < 50) begin tick(); n++; end
        if (n >= 50) to_flag = 1;
        tick();
        s_arvalid = 0;
        cyc = 0; beat = 0;
        while (beat <= len && cyc < 400) begin
            s_rready = use_pat ? pat[cyc % 4] : 1'b1;
            #1;
            if (s_rvalid) begin
                if (first_rv < 0) first_rv = cyc;
                if (held && (s_rdata !== pd || s_rlast !== pl)) unstable = 1;
                if (s_rready) begin
                    rd[beat] = s_rdata; rl[beat] = s_rlast; beat++; held = 0;
                end else begin
                    held = 1; pd = s_rdata; pl = s_rlast;
                end
            end
            tick();
            cyc++;
        end
        if (beat <= len) to_flag = 1;
        s_rready = 0;
        exp_rd++;
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (3) tick();
        rst = 0;
        #1;
        checks++; if (s_bvalid !== 1'b0) begin errors++; $display("FAIL reset_bvalid got %b exp 0", s_bvalid); end
        checks++; if (s_rvalid !== 1'b0 || s_rlast !== 1'b0) begin errors++; $display("FAIL reset_rvalid got %b/%b exp 0/0", s_rvalid, s_rlast); end
        checks++; if (err_wlast !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err_wlast); end
        checks++; if (wr_bursts !== 32'd0 || rd_bursts !== 32'd0) begin errors++; $display("FAIL reset_cnt got %0d/%0d exp 0/0", wr_bursts, rd_bursts); end
        checks++; if (s_rdata !== 512'd0) begin errors++; $display("FAIL reset_rdata got %h exp 0", s_rdata); end
        checks++; if (s_awready !== 1'b1 || s_arready !== 1'b1 || s_wready !== 1'b0) begin errors++; $display("FAIL reset_ready got aw=%b ar=%b w=%b exp 1 1 0", s_awready, s_arready, s_wready); end
    endtask

    task automatic test_write_read();
        logic [31:0] v;
        for (int k = 0; k < 4; k++) begin
            v = 32'hA0 + k;
            wd[k] = {16{v}}; ws[k] = '1;
        end
        do_write(64'h1000, 3, -1, -1);
        checks++; if (to_flag || early_b) begin errors++; $display("FAIL wr_proto got to=%b early_b=%b exp 0 0", to_flag, early_b); end
        checks++; if (b_delay !== 0 || b_after !== 1'b0) begin errors++; $display("FAIL wr_bvalid got delay=%0d after=%b exp 0 0", b_delay, b_after); end
        checks++; if (wr_bursts !== exp_wr) begin errors++; $display("FAIL wr_bursts got %0d exp %0d", wr_bursts, exp_wr); end
        do_read(64'h1000, 3, 0);
        checks++; if (to_flag || first_rv !== 1) begin errors++; $display("FAIL rd_latency got to=%b first=%0d exp 0 1", to_flag, first_rv); end
        for (int k = 0; k < 4; k++) begin
            v = 32'hA0 + k;
            checks++; if (rd[k] !== {16{v}} || rl[k] !== (k == 3)) begin errors++; $display("FAIL rd_beat%0d got %h last=%b exp %h last=%b", k, rd[k], rl[k], {16{v}}, k == 3); end
        end
        checks++; if (rd_bursts !== exp_rd) begin errors++; $display("FAIL rd_bursts got %0d exp %0d", rd_bursts, exp_rd); end
    endtask

    task automatic test_strobe();
        logic [511:0] e;
        wd[0] = '1; ws[0] = '1;
        do_write(64'h0, 0, -1, -1);
        wd[0] = '0; ws[0] = 64'h0000_0000_0000_000F;
        do_write(64'h0, 0, -1, -1);
        do_read(64'h0, 0, 0);
        e = {{60{8'hFF}}, 32'h0};
        checks++; if (rd[0] !== e || rl[0] !== 1'b1) begin errors++; $display("FAIL strobe got %h exp %h", rd[0], e); end
    endtask

    task automatic test_wrap();
        wd[0] = {64{8'h11}}; wd[1] = {64{8'h22}}; ws[0] = '1; ws[1] = '1;
        do_write(64'hFFC0, 1, -1, -1);
        do_read(64'hFFC0, 0, 0);
        checks++; if (rd[0] !== {64{8'h11}}) begin errors++; $display("FAIL wrap_last got %h exp %h", rd[0], {64{8'h11}}); end
        do_read(64'h0, 0, 0);
        checks++; if (rd[0] !== {64{8'h22}}) begin errors++; $display("FAIL wrap_zero got %h exp %h", rd[0], {64{8'h22}}); end
    endtask

    task automatic test_backpressure();
        for (int k = 0; k < 2; k++) begin
            for (int w = 0; w < 16; w++) wd[k][w*32 +: 32] = $urandom;
            ws[k] = '1;
        end
        do_write(64'h2040, 1, -1, 1);
        checks++; if (stall_leak !== 0 || to_flag) begin errors++; $display("FAIL stall_wready got %0d ready cycles exp 0", stall_leak); end
        do_read(64'h2040, 1, 1);
        checks++; if (unstable || to_flag) begin errors++; $display("FAIL rready_stable got unstable=%b to=%b exp 0 0", unstable, to_flag); end
        for (int k = 0; k < 2; k++) begin
            checks++; if (rd[k] !== mdl[(lidx(64'h2040) + k) % 1024] || rl[k] !== (k == 1)) begin errors++; $display("FAIL bp_beat%0d got %h last=%b exp %h", k, rd[k], rl[k], mdl[(lidx(64'h2040) + k) % 1024]); end
        end
    endtask

    task automatic test_wlast_err();
        checks++; if (err_wlast !== 1'b0) begin errors++; $display("FAIL err_pre got %b exp 0", err_wlast); end
        for (int k = 0; k < 3; k++) begin
            for (int w = 0; w < 16; w++) wd[k][w*32 +: 32] = $urandom;
            ws[k] = '1;
        end
        do_write(64'h3000, 2, 1, -1);
        checks++; if (err_wlast !== 1'b1) begin errors++; $display("FAIL err_wlast got %b exp 1", err_wlast); end
        checks++; if (to_flag || early_b || b_delay !== 0 || b_after !== 1'b0 || wr_bursts !== exp_wr) begin errors++; $display("FAIL err_burst got early=%b delay=%0d after=%b wr=%0d exp 0 0 0 %0d", early_b, b_delay, b_after, wr_bursts, exp_wr); end
        do_read(64'h3000, 2, 0);
        for (int k = 0; k < 3; k++) begin
            checks++; if (rd[k] !== mdl[(lidx(64'h3000) + k) % 1024]) begin errors++; $display("FAIL err_beat%0d got %h exp %h", k, rd[k], mdl[(lidx(64'h3000) + k) % 1024]); end
        end
    endtask

    task automatic test_random();
        logic [63:0] a;
        int len;
        for (int t = 0; t < 8; t++) begin
            a = {$urandom, $urandom};
            len = $urandom_range(0, 7);
            for (int k = 0; k <= len; k++) begin
                for (int w = 0; w < 16; w++) wd[k][w*32 +: 32] = $urandom;
                ws[k] = '1;
            end
            do_write(a, len, -1, -1);
            for (int k = 0; k <= len; k++) begin
                for (int w = 0; w < 16; w++) wd[k][w*32 +: 32] = $urandom;
                ws[k] = {$urandom, $urandom};
            end
            do_write(a, len, -1, -1);
            do_read(a, len, 1'($urandom_range(0, 1)));
            for (int k = 0; k <= len; k++) begin
                checks++; if (rd[k] !== mdl[(lidx(a) + k) % 1024] || rl[k] !== (k == len)) begin errors++; $display("FAIL rand%0d_beat%0d got %h last=%b exp %h last=%b", t, k, rd[k], rl[k], mdl[(lidx(a) + k) % 1024], k == len); end
            end
            checks++; if (wr_bursts !== exp_wr || rd_bursts !== exp_rd) begin errors++; $display("FAIL rand%0d_cnt got %0d/%0d exp %0d/%0d", t, wr_bursts, rd_bursts, exp_wr, exp_rd); end
        end
    endtask

    task automatic test_reset_mid();
        int n;
        s_arvalid = 1; s_araddr = 64'h1000; s_arlen = 8'd3;
        #1;
        n = 0;
        while (!s_arready && n < 50) begin tick(); n++; end
        tick();
        s_arvalid = 0; s_rready = 1;
        while (!s_rvalid && n < 100) begin tick(); n++; end
        tick();
        s_rready = 0;
        while (!s_rvalid && n < 150) begin tick(); n++; end
        checks++; if (n >= 150) begin errors++; $display("FAIL mid_reach got timeout exp rvalid on beat 1"); end
        rst = 1;
        tick();
        rst = 0;
        exp_wr = 0; exp_rd = 0;
        #1;
        checks++; if (s_rvalid !== 1'b0 || s_arready !== 1'b1) begin errors++; $display("FAIL mid_state got rvalid=%b arready=%b exp 0 1", s_rvalid, s_arready); end
        checks++; if (rd_bursts !== 32'd0 || wr_bursts !== 32'd0 || err_wlast !== 1'b0) begin errors++; $display("FAIL mid_cnt got rd=%0d wr=%0d err=%b exp 0 0 0", rd_bursts, wr_bursts, err_wlast); end
        do_read(64'h1000, 3, 0);
        for (int k = 0; k < 4; k++) begin
            checks++; if (rd[k] !== mdl[(lidx(64'h1000) + k) % 1024]) begin errors++; $display("FAIL mid_mem%0d got %h exp %h", k, rd[k], mdl[(lidx(64'h1000) + k) % 1024]); end
        end
        checks++; if (rd_bursts !== 32'd1) begin errors++; $display("FAIL mid_rdb got %0d exp 1", rd_bursts); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_read();
        test_strobe();
        test_wrap();
        test_backpressure();
        test_wlast_err();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
